// File: rtl/log_entry_rd_ctrl_pkg.sv
// Shared types for the log entry read controller: FSM states, header records, widths.
// Struct field widths follow the LR_* defaults below.
package log_rd_pkg;

    localparam int LR_LOG_IDX_W   = 10;
    localparam int LR_DATA_ADDR_W = 12;
    localparam int LR_BEATS_W     = 8;
    localparam int LR_DATA_W      = 512;
    localparam int LR_MAX_OUTST   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_REQ,
        ST_HDR_RESP,
        ST_HDR_OUT,
        ST_DATA,
        ST_ERR_OUT
    } log_rd_state_e;

    typedef struct packed {
        logic [LR_DATA_ADDR_W-1:0] data_addr;
        logic [LR_BEATS_W-1:0]     beats;
    } log_rd_hdr_t;

    typedef struct packed {
        logic                  err;
        logic [LR_BEATS_W-1:0] beats;
    } log_rd_out_hdr_t;

    // Ring-distance test: an empty log (head == tail) yields zero length, so nothing hits.
    function automatic logic idx_in_log(
        input logic [LR_LOG_IDX_W-1:0] idx,
        input logic [LR_LOG_IDX_W-1:0] head,
        input logic [LR_LOG_IDX_W-1:0] tail
    );
        logic [LR_LOG_IDX_W-1:0] w_off;
        logic [LR_LOG_IDX_W-1:0] w_len;
        w_off = idx - head;
        w_len = tail - head;
        return w_off < w_len;
    endfunction

endpackage

// File: rtl/log_entry_rd_ctrl_if.sv
// Handshake bundle between the read controller and its requester, log memories and output streams.
interface log_entry_rd_ctrl_if
    import log_rd_pkg::*;
#(
    parameter int LOG_IDX_W   = LR_LOG_IDX_W,
    parameter int DATA_ADDR_W = LR_DATA_ADDR_W,
    parameter int BEATS_W     = LR_BEATS_W,
    parameter int DATA_W      = LR_DATA_W
);
    logic                   rd_req_val;
    logic [LOG_IDX_W-1:0]   rd_req_idx;
    logic                   rd_req_rdy;

    logic                   hdr_mem_rd_req_val;
    logic [LOG_IDX_W-1:0]   hdr_mem_rd_req_addr;
    logic                   hdr_mem_rd_req_rdy;
    logic                   hdr_mem_rd_resp_val;
    logic [DATA_ADDR_W-1:0] hdr_mem_rd_resp_data_addr;
    logic [BEATS_W-1:0]     hdr_mem_rd_resp_beats;
    logic                   hdr_mem_rd_resp_rdy;

    logic                   data_mem_rd_req_val;
    logic [DATA_ADDR_W-1:0] data_mem_rd_req_addr;
    logic                   data_mem_rd_req_rdy;
    logic                   data_mem_rd_resp_val;
    logic [DATA_W-1:0]      data_mem_rd_resp_data;
    logic                   data_mem_rd_resp_rdy;

    logic                   out_hdr_val;
    logic                   out_hdr_err;
    logic [BEATS_W-1:0]     out_hdr_beats;
    logic                   out_hdr_rdy;
    logic                   out_data_val;
    logic [DATA_W-1:0]      out_data;
    logic                   out_data_last;
    logic                   out_data_rdy;

    modport master (
        input  rd_req_val, rd_req_idx,
        output rd_req_rdy,
        output hdr_mem_rd_req_val, hdr_mem_rd_req_addr,
        input  hdr_mem_rd_req_rdy,
        input  hdr_mem_rd_resp_val, hdr_mem_rd_resp_data_addr, hdr_mem_rd_resp_beats,
        output hdr_mem_rd_resp_rdy,
        output data_mem_rd_req_val, data_mem_rd_req_addr,
        input  data_mem_rd_req_rdy,
        input  data_mem_rd_resp_val, data_mem_rd_resp_data,
        output data_mem_rd_resp_rdy,
        output out_hdr_val, out_hdr_err, out_hdr_beats,
        input  out_hdr_rdy,
        output out_data_val, out_data, out_data_last,
        input  out_data_rdy
    );

    modport slave (
        output rd_req_val, rd_req_idx,
        input  rd_req_rdy,
        input  hdr_mem_rd_req_val, hdr_mem_rd_req_addr,
        output hdr_mem_rd_req_rdy,
        output hdr_mem_rd_resp_val, hdr_mem_rd_resp_data_addr, hdr_mem_rd_resp_beats,
        input  hdr_mem_rd_resp_rdy,
        input  data_mem_rd_req_val, data_mem_rd_req_addr,
        output data_mem_rd_req_rdy,
        output data_mem_rd_resp_val, data_mem_rd_resp_data,
        input  data_mem_rd_resp_rdy,
        input  out_hdr_val, out_hdr_err, out_hdr_beats,
        output out_hdr_rdy,
        input  out_data_val, out_data, out_data_last,
        output out_data_rdy
    );

endinterface

// File: rtl/log_entry_rd_ctrl_beat_issuer.sv
// Payload phase bookkeeping: issues ring-wrapped beat reads, bounds reads in flight,
// counts forwarded beats and flags the final one.
module log_rd_beat_issuer
    import log_rd_pkg::*;
#(
    parameter int DATA_ADDR_W = LR_DATA_ADDR_W,
    parameter int BEATS_W     = LR_BEATS_W,
    parameter int MAX_OUTST   = LR_MAX_OUTST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_active,
    input  logic [DATA_ADDR_W-1:0] i_data_addr,
    input  logic [BEATS_W-1:0]     i_beats,
    output logic                   o_req_val,
    output logic [DATA_ADDR_W-1:0] o_req_addr,
    input  logic                   i_req_rdy,
    input  logic                   i_resp_val,
    input  logic                   i_out_rdy,
    output logic                   o_last,
    output logic                   o_done
);
    localparam int OUTST_W = $clog2(MAX_OUTST + 1);
    localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);
    localparam logic [OUTST_W-1:0] OUTST_ONE = OUTST_W'(1);
    localparam logic [BEATS_W:0]   CNT_ONE   = (BEATS_W + 1)'(1);

    logic [BEATS_W:0]   r_issued;
    logic [BEATS_W:0]   r_fwd;
    logic [OUTST_W-1:0] r_outst;

    logic [BEATS_W:0]   w_beats_ext;
    logic               w_issue_fire;
    logic               w_fwd_fire;

    assign w_beats_ext  = {1'b0, i_beats};
    assign o_req_val    = i_active && (r_issued < w_beats_ext) && (r_outst < OUTST_MAX);
    assign o_req_addr   = i_data_addr + DATA_ADDR_W'(r_issued);
    assign w_issue_fire = o_req_val && i_req_rdy;
    assign w_fwd_fire   = i_active && i_resp_val && i_out_rdy;
    assign o_last       = i_active && (r_fwd == (w_beats_ext - CNT_ONE));
    assign o_done       = w_fwd_fire && o_last;

    // Counters idle at zero whenever the payload phase is not running.
    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_issued <= '0;
            r_fwd    <= '0;
            r_outst  <= '0;
        end else begin
            if (w_issue_fire) begin
                r_issued <= r_issued + CNT_ONE;
            end
            if (w_fwd_fire) begin
                r_fwd <= r_fwd + CNT_ONE;
            end
            case ({w_issue_fire, w_fwd_fire})
                2'b10:   r_outst <= r_outst + OUTST_ONE;
                2'b01:   r_outst <= r_outst - OUTST_ONE;
                default: r_outst <= r_outst;
            endcase
        end
    end

endmodule

// File: rtl/log_entry_rd_ctrl.sv
// Replica log read controller: range-checks an entry index, fetches its header,
// emits it, then streams the payload beats with last.
module log_entry_rd_ctrl
    import log_rd_pkg::*;
#(
    parameter int LOG_IDX_W   = LR_LOG_IDX_W,
    parameter int DATA_ADDR_W = LR_DATA_ADDR_W,
    parameter int BEATS_W     = LR_BEATS_W,
    parameter int DATA_W      = LR_DATA_W,
    parameter int MAX_OUTST   = LR_MAX_OUTST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LOG_IDX_W-1:0] log_head_idx,
    input  logic [LOG_IDX_W-1:0] log_tail_idx,
    output logic                 rd_idle,
    log_entry_rd_ctrl_if.master  bus
);
    log_rd_state_e        r_state;
    logic [LOG_IDX_W-1:0] r_idx;
    log_rd_hdr_t          r_hdr;
    log_rd_out_hdr_t      r_out_hdr;
    logic                 r_req_rdy;
    logic                 r_hdr_req_val;
    logic                 r_hdr_resp_rdy;
    logic                 r_out_hdr_val;
    logic                 r_idle;

    logic                 w_hit;
    logic                 w_in_data;
    logic                 w_last;
    logic                 w_done;

    assign w_hit     = idx_in_log(bus.rd_req_idx, log_head_idx, log_tail_idx);
    assign w_in_data = (r_state == ST_DATA);

    log_rd_beat_issuer #(
        .DATA_ADDR_W (DATA_ADDR_W),
        .BEATS_W     (BEATS_W),
        .MAX_OUTST   (MAX_OUTST)
    ) u_issuer (
        .clk         (clk),
        .rst         (rst),
        .i_active    (w_in_data),
        .i_data_addr (r_hdr.data_addr),
        .i_beats     (r_hdr.beats),
        .o_req_val   (bus.data_mem_rd_req_val),
        .o_req_addr  (bus.data_mem_rd_req_addr),
        .i_req_rdy   (bus.data_mem_rd_req_rdy),
        .i_resp_val  (bus.data_mem_rd_resp_val),
        .i_out_rdy   (bus.out_data_rdy),
        .o_last      (w_last),
        .o_done      (w_done)
    );

    assign bus.rd_req_rdy           = r_req_rdy;
    assign bus.hdr_mem_rd_req_val   = r_hdr_req_val;
    assign bus.hdr_mem_rd_req_addr  = r_idx;
    assign bus.hdr_mem_rd_resp_rdy  = r_hdr_resp_rdy;
    assign bus.out_hdr_val          = r_out_hdr_val;
    assign bus.out_hdr_err          = r_out_hdr.err;
    assign bus.out_hdr_beats        = r_out_hdr.beats;
    assign rd_idle                  = r_idle;

    // Payload return path is a straight passthrough while streaming, blocked otherwise.
    assign bus.out_data_val         = w_in_data && bus.data_mem_rd_resp_val;
    assign bus.out_data             = bus.data_mem_rd_resp_data;
    assign bus.out_data_last        = w_last;
    assign bus.data_mem_rd_resp_rdy = w_in_data && bus.out_data_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_hdr          <= '0;
            r_out_hdr      <= '0;
            r_req_rdy      <= 1'b1;
            r_hdr_req_val  <= 1'b0;
            r_hdr_resp_rdy <= 1'b0;
            r_out_hdr_val  <= 1'b0;
            r_idle         <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rd_req_val) begin
                        r_idx     <= bus.rd_req_idx;
                        r_req_rdy <= 1'b0;
                        r_idle    <= 1'b0;
                        if (w_hit) begin
                            r_state       <= ST_HDR_REQ;
                            r_hdr_req_val <= 1'b1;
                        end else begin
                            r_state       <= ST_ERR_OUT;
                            r_out_hdr_val <= 1'b1;
                            r_out_hdr     <= '{err: 1'b1, beats: '0};
                        end
                    end
                end
                ST_HDR_REQ: begin
                    if (bus.hdr_mem_rd_req_rdy) begin
                        r_state        <= ST_HDR_RESP;
                        r_hdr_req_val  <= 1'b0;
                        r_hdr_resp_rdy <= 1'b1;
                    end
                end
                ST_HDR_RESP: begin
                    if (bus.hdr_mem_rd_resp_val) begin
                        r_state        <= ST_HDR_OUT;
                        r_hdr          <= '{data_addr: bus.hdr_mem_rd_resp_data_addr,
                                            beats: bus.hdr_mem_rd_resp_beats};
                        r_hdr_resp_rdy <= 1'b0;
                        r_out_hdr_val  <= 1'b1;
                        r_out_hdr      <= '{err: 1'b0, beats: bus.hdr_mem_rd_resp_beats};
                    end
                end
                ST_HDR_OUT: begin
                    if (bus.out_hdr_rdy) begin
                        r_out_hdr_val <= 1'b0;
                        if (r_hdr.beats == '0) begin
                            r_state   <= ST_IDLE;
                            r_req_rdy <= 1'b1;
                            r_idle    <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_ERR_OUT: begin
                    if (bus.out_hdr_rdy) begin
                        r_state       <= ST_IDLE;
                        r_out_hdr_val <= 1'b0;
                        r_req_rdy     <= 1'b1;
                        r_idle        <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_req_rdy <= 1'b1;
                        r_idle    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_req_rdy <= 1'b1;
                    r_idle    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_entry_rd_ctrl.sv
// Scoreboard bench: requests push expected headers, memory addresses and beats;
// a monitor with memory models pops and compares on every handshake.
module tb_log_entry_rd_ctrl;
    import log_rd_pkg::*;

    localparam int LIW = 10;
    localparam int DAW = 12;
    localparam int BW  = 8;
    localparam int DW  = 512;
    localparam int MO  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [LIW-1:0] head = '0;
    logic [LIW-1:0] tail = '0;
    logic           rd_idle;

    log_entry_rd_ctrl_if #(.LOG_IDX_W(LIW), .DATA_ADDR_W(DAW), .BEATS_W(BW), .DATA_W(DW)) bus ();

    log_entry_rd_ctrl #(
        .LOG_IDX_W(LIW), .DATA_ADDR_W(DAW), .BEATS_W(BW), .DATA_W(DW), .MAX_OUTST(MO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .log_head_idx (head),
        .log_tail_idx (tail),
        .rd_idle      (rd_idle),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        int beats;
    } exp_hdr_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_hdr_t      q_hdr[$];
    int            q_haddr[$];
    int            q_daddr[$];
    logic [DW-1:0] q_data[$];
    bit            q_last[$];
    int            dpend[$];
    int            hm_addr[1024];
    int            hm_beats[1024];
    int            mem_rdy_pct = 70;
    int            resp_pct    = 80;
    int            out_rdy_pct = 75;
    bit            stall       = 1'b0;
    int            dreq_total  = 0;
    int            dfwd_total  = 0;
    logic [15:0]   salt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got an unexpected handshake, expected none", name);
    endtask

    function automatic logic [DW-1:0] beat_val(input int a);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) begin
            v[i*32 +: 32] = {salt ^ 16'(i), 4'h5, 12'(a)};
        end
        return v;
    endfunction

    // Memory models and output monitor: drive at negedge, evaluate handshakes 2 time units later.
    initial begin
        int hpend;
        int haddr;
        int outst;
        int o0;
        exp_hdr_t e;
        hpend = 0;
        haddr = 0;
        outst = 0;
        forever begin
            @(negedge clk);
            bus.hdr_mem_rd_req_rdy        = ($urandom_range(99) < mem_rdy_pct);
            bus.hdr_mem_rd_resp_val       = (hpend != 0) && ($urandom_range(99) < resp_pct);
            bus.hdr_mem_rd_resp_data_addr = DAW'(hm_addr[haddr]);
            bus.hdr_mem_rd_resp_beats     = BW'(hm_beats[haddr]);
            bus.data_mem_rd_req_rdy       = ($urandom_range(99) < mem_rdy_pct);
            if (dpend.size() > 0 && $urandom_range(99) < resp_pct) begin
                bus.data_mem_rd_resp_val  = 1'b1;
                bus.data_mem_rd_resp_data = beat_val(dpend[0]);
            end else begin
                bus.data_mem_rd_resp_val  = 1'b0;
                bus.data_mem_rd_resp_data = '0;
            end
            bus.out_hdr_rdy  = ($urandom_range(99) < out_rdy_pct);
            bus.out_data_rdy = !stall && ($urandom_range(99) < out_rdy_pct);
            #2;
            if (rst) begin
                hpend = 0;
                outst = 0;
                dpend.delete();
                q_hdr.delete();
                q_haddr.delete();
                q_daddr.delete();
                q_data.delete();
                q_last.delete();
            end else begin
                o0 = outst;
                if (bus.hdr_mem_rd_resp_val && bus.hdr_mem_rd_resp_rdy) hpend = 0;
                if (bus.hdr_mem_rd_req_val && bus.hdr_mem_rd_req_rdy) begin
                    if (q_haddr.size() == 0) unexpected("hdr_mem_req");
                    else chk("hdr_mem_addr", 64'(bus.hdr_mem_rd_req_addr), 64'(q_haddr.pop_front()));
                    hpend = 1;
                    haddr = int'(bus.hdr_mem_rd_req_addr);
                end
                if (bus.data_mem_rd_resp_val && bus.data_mem_rd_resp_rdy) begin
                    void'(dpend.pop_front());
                    outst--;
                end
                if (bus.data_mem_rd_req_val && bus.data_mem_rd_req_rdy) begin
                    chk("outst_below_max", 64'(o0 < MO), 64'd1);
                    if (q_daddr.size() == 0) unexpected("data_mem_req");
                    else chk("data_mem_addr", 64'(bus.data_mem_rd_req_addr), 64'(q_daddr.pop_front()));
                    dpend.push_back(int'(bus.data_mem_rd_req_addr));
                    dreq_total++;
                    outst++;
                end
                if (bus.out_hdr_val && bus.out_hdr_rdy) begin
                    if (q_hdr.size() == 0) unexpected("out_hdr");
                    else begin
                        e = q_hdr.pop_front();
                        chk("out_hdr_err", 64'(bus.out_hdr_err), 64'(e.err));
                        chk("out_hdr_beats", 64'(bus.out_hdr_beats), 64'(e.beats));
                    end
                end
                if (bus.out_data_val && bus.out_data_rdy) begin
                    if (q_data.size() == 0) unexpected("out_data");
                    else begin
                        logic [DW-1:0] xd;
                        xd = q_data.pop_front();
                        n_tests++;
                        if (bus.out_data !== xd) begin
                            n_fail++;
                            $display("FAIL out_data: got %0h expected %0h (low 64 bits)",
                                     bus.out_data[63:0], xd[63:0]);
                        end
                        chk("out_data_last", 64'(bus.out_data_last), 64'(q_last.pop_front()));
                    end
                    dfwd_total++;
                end
            end
        end
    end

    // Issues one request and records what the log should return for it.
    task automatic issue(input int h, input int t, input int idx);
        int  c;
        bit  hit;
        int  b;
        exp_hdr_t e;
        head = LIW'(h);
        tail = LIW'(t);
        @(negedge clk);
        bus.rd_req_val = 1'b1;
        bus.rd_req_idx = LIW'(idx);
        #1;
        c = 0;
        while (!bus.rd_req_rdy && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (!bus.rd_req_rdy) begin
            unexpected("req_accept_timeout");
        end else begin
            hit = 1'b0;
            for (int k = 0; k < 1024 && ((h + k) % 1024) != t; k++) begin
                if (((h + k) % 1024) == idx) hit = 1'b1;
            end
            if (hit) begin
                b = hm_beats[idx];
                e.err = 1'b0;
                e.beats = b;
                q_hdr.push_back(e);
                q_haddr.push_back(idx);
                for (int k = 0; k < b; k++) begin
                    q_daddr.push_back((hm_addr[idx] + k) % 4096);
                    q_data.push_back(beat_val((hm_addr[idx] + k) % 4096));
                    q_last.push_back(k == b - 1);
                end
            end else begin
                e.err = 1'b1;
                e.beats = 0;
                q_hdr.push_back(e);
            end
        end
        @(negedge clk);
        bus.rd_req_val = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            #3;
            c++;
        end while (!(q_hdr.size() == 0 && q_haddr.size() == 0 && q_daddr.size() == 0 &&
                     q_data.size() == 0 && rd_idle) && c < 3000);
        if (c >= 3000) unexpected("entry_done_timeout");
        chk("rd_idle_after", 64'(rd_idle), 64'd1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req_rdy"}, 64'(bus.rd_req_rdy), 64'd1);
        chk({tag, "_idle"}, 64'(rd_idle), 64'd1);
        chk({tag, "_vals"}, 64'({bus.hdr_mem_rd_req_val, bus.data_mem_rd_req_val,
                                 bus.out_hdr_val, bus.out_data_val, bus.hdr_mem_rd_resp_rdy}), 64'd0);
    endtask

    initial begin
        int base;
        int c;
        int h;
        salt = 16'($urandom);
        bus.rd_req_val = 1'b0;
        bus.rd_req_idx = '0;
        for (int i = 0; i < 1024; i++) begin
            hm_addr[i]  = $urandom_range(4095);
            hm_beats[i] = $urandom_range(0, 12);
        end
        hm_addr[3]  = 'h100; hm_beats[3]  = 4;
        hm_addr[1]  = 'h010; hm_beats[1]  = 2;
        hm_addr[11] = 'hFFE; hm_beats[11] = 3;
        hm_addr[20] = 'h200; hm_beats[20] = 8;
        hm_addr[7]  = 'h050; hm_beats[7]  = 0;
        hm_addr[9]  = 'h300; hm_beats[9]  = 6;

        repeat (3) @(negedge clk);
        #3;
        check_quiet("reset");
        rst = 1'b0;

        issue(0, 5, 3);    wait_done();
        issue(8, 2, 1);    wait_done();
        issue(8, 2, 5);    wait_done();
        issue(5, 5, 5);    wait_done();
        issue(0, 20, 11);  wait_done();
        issue(0, 20, 7);   wait_done();

        // Consumer stalled: only MAX_OUTST reads may be in flight.
        mem_rdy_pct = 100;
        resp_pct    = 100;
        stall       = 1'b1;
        base        = dreq_total;
        issue(0, 30, 20);
        c = 0;
        while (dreq_total - base < MO && c < 100) begin
            @(negedge clk);
            #3;
            c++;
        end
        repeat (10) @(negedge clk);
        #3;
        chk("stall_reads_in_flight", 64'(dreq_total - base), 64'(MO));
        stall = 1'b0;
        wait_done();

        // Reset in the middle of a 6-beat entry.
        base = dfwd_total;
        issue(0, 20, 9);
        c = 0;
        while (dfwd_total - base < 2 && c < 200) begin
            @(negedge clk);
            #3;
            c++;
        end
        rst = 1'b1;
        @(negedge clk);
        #3;
        check_quiet("mid_reset");
        rst = 1'b0;
        issue(0, 20, 3);
        wait_done();

        mem_rdy_pct = 70;
        resp_pct    = 80;
        for (int n = 0; n < 25; n++) begin
            mem_rdy_pct = $urandom_range(40, 100);
            resp_pct    = $urandom_range(40, 100);
            out_rdy_pct = $urandom_range(40, 100);
            h = $urandom_range(1023);
            issue(h, (h + $urandom_range(0, 40)) % 1024, (h + $urandom_range(0, 45)) % 1024);
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
